// File: rtl/router_pkg.sv
// router_pkg: definitions shared by the router control FSM and its wait timer.
//   state_e      - controller state encoding
//   flags_t      - the registered 1-bit status outputs of the controller
//   clog2        - ceiling log2 for parameter-derived widths
//   *_DEF        - default parameter values
package router_pkg;

   localparam int unsigned NUM_CH_DEF   = 3;
   localparam int unsigned DATA_W_DEF   = 8;
   localparam int unsigned WAIT_MAX_DEF = 255;

   typedef enum logic [3:0] {
      DECODE_ADDRESS,
      WAIT_TILL_EMPTY,
      LOAD_FIRST_DATA,
      LOAD_DATA,
      FIFO_FULL_STATE,
      LOAD_AFTER_FULL,
      LOAD_PARITY,
      CHECK_PARITY_ERROR,
      DROP_PKT
   } state_e;

   typedef struct packed {
      logic detect_add;
      logic lfd_state;
      logic ld_state;
      logic full_state;
      logic laf_state;
      logic write_enb_reg;
      logic rst_int_reg;
      logic busy;
      logic pkt_dropped;
   } flags_t;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return r;
   endfunction

   // Moore part of the status outputs; pkt_dropped depends on the transition
   // and is filled in by the caller.
   function automatic flags_t decode_flags(input state_e s);
      flags_t f;
      f               = '0;
      f.detect_add    = (s == DECODE_ADDRESS);
      f.lfd_state     = (s == LOAD_FIRST_DATA);
      f.ld_state      = (s == LOAD_DATA);
      f.full_state    = (s == FIFO_FULL_STATE);
      f.laf_state     = (s == LOAD_AFTER_FULL);
      f.rst_int_reg   = (s == CHECK_PARITY_ERROR);
      f.write_enb_reg = (s == LOAD_DATA) || (s == LOAD_PARITY) || (s == LOAD_AFTER_FULL);
      f.busy          = !((s == DECODE_ADDRESS) || (s == LOAD_DATA) || (s == DROP_PKT));
      return f;
   endfunction

endpackage

// File: rtl/router_wait_timer.sv
// router_wait_timer: counts cycles spent waiting for a destination FIFO to drain.
//   clk, rst  - clock, synchronous active-high reset
//   clr       - hold the count at zero (asserted while not waiting)
//   en        - count this cycle (asserted while waiting)
//   expired   - this waiting cycle brings the count to WAIT_MAX (never when WAIT_MAX=0)
module router_wait_timer
   import router_pkg::*;
#(
   parameter int unsigned WAIT_MAX = WAIT_MAX_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned      CNT_W   = (WAIT_MAX == 0) ? 1 : clog2(WAIT_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_MAX);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_q <= '0;
      end else if (en && (cnt_q != CNT_MAX)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   // cnt_q holds completed waiting cycles, so the current one is cnt_q+1.
   assign expired = (WAIT_MAX != 0) && en && ((33'(cnt_q) + 33'd1) >= 33'(WAIT_MAX));

endmodule

// File: rtl/router_ctrl_fsm.sv
// router_ctrl_fsm: packet router controller. Decodes the header address, waits
// for the destination FIFO, sequences header/payload/parity loads and drops
// packets for invalid addresses or wait timeouts.
//   clk, rst                      - clock, synchronous active-high reset
//   pkt_valid, data_in            - incoming byte stream, address in data_in LSBs
//   parity_done, low_pkt_valid    - packet-end indications from the datapath
//   fifo_full/empty, soft_reset   - per-channel FIFO status and flush requests
//   detect_add .. pkt_dropped     - registered state-decoded status outputs
//   dest_sel                      - one-hot selected channel, zero when idle/dropping
module router_ctrl_fsm
   import router_pkg::*;
#(
   parameter int unsigned NUM_CH   = NUM_CH_DEF,
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned WAIT_MAX = WAIT_MAX_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pkt_valid,
   input  logic [DATA_W-1:0] data_in,
   input  logic              parity_done,
   input  logic              low_pkt_valid,
   input  logic [NUM_CH-1:0] fifo_full,
   input  logic [NUM_CH-1:0] fifo_empty,
   input  logic [NUM_CH-1:0] soft_reset,
   output logic              detect_add,
   output logic              lfd_state,
   output logic              ld_state,
   output logic              full_state,
   output logic              laf_state,
   output logic              write_enb_reg,
   output logic              rst_int_reg,
   output logic              busy,
   output logic              pkt_dropped,
   output logic [NUM_CH-1:0] dest_sel
);

   localparam int unsigned ADDR_W = clog2(NUM_CH);

   // Out-of-range addresses map to all-zero, which doubles as the validity test.
   function automatic logic [NUM_CH-1:0] to_onehot(input logic [ADDR_W-1:0] a);
      logic [NUM_CH-1:0] oh;
      oh = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (a == ADDR_W'(i)) oh[i] = 1'b1;
      end
      return oh;
   endfunction

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   flags_t            flags_q, flags_d;
   logic [NUM_CH-1:0] dest_sel_q, dest_sel_d;
   logic [NUM_CH-1:0] hdr_oh, addr_oh_q;
   logic              empty_sel, full_sel, soft_sel, wait_expired;
   logic              unused_data;

   assign hdr_oh      = to_onehot(data_in[ADDR_W-1:0]);
   assign addr_oh_q   = to_onehot(addr_q);
   assign empty_sel   = |(fifo_empty & addr_oh_q);
   assign full_sel    = |(fifo_full  & addr_oh_q);
   assign soft_sel    = |(soft_reset & addr_oh_q);
   assign unused_data = ^data_in;

   router_wait_timer #(
      .WAIT_MAX (WAIT_MAX)
   ) u_wait_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (state_q != WAIT_TILL_EMPTY),
      .en      (state_q == WAIT_TILL_EMPTY),
      .expired (wait_expired)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      case (state_q)
         DECODE_ADDRESS: begin
            if (pkt_valid) begin
               addr_d = data_in[ADDR_W-1:0];
               if (hdr_oh == '0)                state_d = DROP_PKT;
               else if (|(fifo_empty & hdr_oh)) state_d = LOAD_FIRST_DATA;
               else                             state_d = WAIT_TILL_EMPTY;
            end
         end
         WAIT_TILL_EMPTY: begin
            if (empty_sel)         state_d = LOAD_FIRST_DATA;
            else if (wait_expired) state_d = DROP_PKT;
         end
         LOAD_FIRST_DATA: state_d = LOAD_DATA;
         LOAD_DATA: begin
            if (full_sel)       state_d = FIFO_FULL_STATE;
            else if (!pkt_valid) state_d = LOAD_PARITY;
         end
         FIFO_FULL_STATE: begin
            if (!full_sel) state_d = LOAD_AFTER_FULL;
         end
         LOAD_AFTER_FULL: begin
            if (parity_done)        state_d = DECODE_ADDRESS;
            else if (low_pkt_valid) state_d = LOAD_PARITY;
            else                    state_d = LOAD_DATA;
         end
         LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
         CHECK_PARITY_ERROR: begin
            state_d = full_sel ? FIFO_FULL_STATE : DECODE_ADDRESS;
         end
         DROP_PKT: begin
            if (!pkt_valid) state_d = DECODE_ADDRESS;
         end
         default: state_d = DECODE_ADDRESS;
      endcase
      // A flush of the active channel aborts whatever is in progress.
      if ((state_q != DECODE_ADDRESS) && soft_sel) state_d = DECODE_ADDRESS;
   end

   // Outputs are registered from the next state so they line up with state_q.
   always_comb begin
      flags_d             = decode_flags(state_d);
      flags_d.pkt_dropped = (state_d == DROP_PKT) && (state_q != DROP_PKT);
      dest_sel_d          = '0;
      if ((state_d != DECODE_ADDRESS) && (state_d != DROP_PKT)) dest_sel_d = to_onehot(addr_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= DECODE_ADDRESS;
         addr_q     <= '0;
         flags_q    <= decode_flags(DECODE_ADDRESS);
         dest_sel_q <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         flags_q    <= flags_d;
         dest_sel_q <= dest_sel_d;
      end
   end

   assign detect_add    = flags_q.detect_add;
   assign lfd_state     = flags_q.lfd_state;
   assign ld_state      = flags_q.ld_state;
   assign full_state    = flags_q.full_state;
   assign laf_state     = flags_q.laf_state;
   assign write_enb_reg = flags_q.write_enb_reg;
   assign rst_int_reg   = flags_q.rst_int_reg;
   assign busy          = flags_q.busy;
   assign pkt_dropped   = flags_q.pkt_dropped;
   assign dest_sel      = dest_sel_q;

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// Bench for router_ctrl_fsm: two instances (WAIT_MAX 255 and 8) share one
// stimulus stream and are compared every cycle against a reference model.
module tb_router_ctrl_fsm;

   localparam int M_DEC = 0, M_WAIT = 1, M_LFD = 2, M_LD = 3, M_FULL = 4,
                  M_LAF = 5, M_LP = 6, M_CPE = 7, M_DROP = 8;

   logic       clk = 1'b0;
   logic       rst, pkt_valid, parity_done, low_pkt_valid;
   logic [7:0] data_in;
   logic [2:0] fifo_full, fifo_empty, soft_reset;

   logic       detect_add_a, lfd_a, ld_a, full_a, laf_a, we_a, ri_a, busy_a, drop_a;
   logic       detect_add_b, lfd_b, ld_b, full_b, laf_b, we_b, ri_b, busy_b, drop_b;
   logic [2:0] dest_a, dest_b;
   logic [11:0] out_a, out_b;

   int n_tests = 0;
   int n_fail  = 0;

   int m_st[2], m_addr[2], m_cnt[2];
   bit m_pulse[2];
   int wmax[2] = '{255, 8};

   always #5 clk = ~clk;

   router_ctrl_fsm #(.NUM_CH(3), .DATA_W(8), .WAIT_MAX(255)) dut_a (
      .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .data_in(data_in),
      .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
      .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
      .detect_add(detect_add_a), .lfd_state(lfd_a), .ld_state(ld_a),
      .full_state(full_a), .laf_state(laf_a), .write_enb_reg(we_a),
      .rst_int_reg(ri_a), .busy(busy_a), .pkt_dropped(drop_a), .dest_sel(dest_a));

   router_ctrl_fsm #(.NUM_CH(3), .DATA_W(8), .WAIT_MAX(8)) dut_b (
      .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .data_in(data_in),
      .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
      .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
      .detect_add(detect_add_b), .lfd_state(lfd_b), .ld_state(ld_b),
      .full_state(full_b), .laf_state(laf_b), .write_enb_reg(we_b),
      .rst_int_reg(ri_b), .busy(busy_b), .pkt_dropped(drop_b), .dest_sel(dest_b));

   assign out_a = {detect_add_a, lfd_a, ld_a, full_a, laf_a, we_a, ri_a, busy_a, drop_a, dest_a};
   assign out_b = {detect_add_b, lfd_b, ld_b, full_b, laf_b, we_b, ri_b, busy_b, drop_b, dest_b};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: one transition per clock from the packet rules.
   task automatic model_step(input int k);
      int nx, a;
      if (rst) begin
         m_st[k] = M_DEC; m_addr[k] = 0; m_cnt[k] = 0; m_pulse[k] = 0;
      end else begin
         nx = m_st[k];
         case (m_st[k])
            M_DEC: if (pkt_valid) begin
               a = int'(data_in[1:0]);
               m_addr[k] = a;
               if (a >= 3)             nx = M_DROP;
               else if (fifo_empty[a]) nx = M_LFD;
               else                    nx = M_WAIT;
            end
            M_WAIT: begin
               m_cnt[k] = m_cnt[k] + 1;
               if (fifo_empty[m_addr[k]])                       nx = M_LFD;
               else if (wmax[k] > 0 && m_cnt[k] >= wmax[k])     nx = M_DROP;
            end
            M_LFD:  nx = M_LD;
            M_LD:   if (fifo_full[m_addr[k]]) nx = M_FULL; else if (!pkt_valid) nx = M_LP;
            M_FULL: if (!fifo_full[m_addr[k]]) nx = M_LAF;
            M_LAF:  nx = parity_done ? M_DEC : (low_pkt_valid ? M_LP : M_LD);
            M_LP:   nx = M_CPE;
            M_CPE:  nx = fifo_full[m_addr[k]] ? M_FULL : M_DEC;
            M_DROP: if (!pkt_valid) nx = M_DEC;
            default: nx = M_DEC;
         endcase
         if (m_st[k] != M_DEC && m_addr[k] < 3 && soft_reset[m_addr[k]]) nx = M_DEC;
         if (nx == M_WAIT && m_st[k] != M_WAIT) m_cnt[k] = 0;
         m_pulse[k] = (nx == M_DROP) && (m_st[k] != M_DROP);
         m_st[k] = nx;
      end
   endtask

   function automatic logic [11:0] exp_out(input int k);
      int s;
      logic [2:0] ds;
      s  = m_st[k];
      ds = (s == M_DEC || s == M_DROP) ? 3'b000 : 3'(1 << m_addr[k]);
      return {s == M_DEC, s == M_LFD, s == M_LD, s == M_FULL, s == M_LAF,
              (s == M_LD || s == M_LP || s == M_LAF), s == M_CPE,
              !(s == M_DEC || s == M_LD || s == M_DROP), m_pulse[k], ds};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      model_step(0);
      model_step(1);
      chk("outs_a", 32'(out_a), 32'(exp_out(0)));
      chk("outs_b", 32'(out_b), 32'(exp_out(1)));
   endtask

   task automatic idle();
      rst = 1'b0; pkt_valid = 1'b0; data_in = 8'h00; parity_done = 1'b0;
      low_pkt_valid = 1'b0; fifo_full = 3'b000; fifo_empty = 3'b111; soft_reset = 3'b000;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      int drop_step, pulses;
      idle();
      rst = 1'b1;
      m_st = '{M_DEC, M_DEC}; m_addr = '{0, 0}; m_cnt = '{0, 0}; m_pulse = '{0, 0};
      step();
      rst = 1'b0;
      chk("rst_outs", 32'(out_a), 32'h800);
      chk("rst_dest", 32'(dest_b), 32'h0);

      // Normal packet to channel 1
      pkt_valid = 1'b1; data_in = 8'h01;
      step();
      chk("s1_lfd", 32'(lfd_a), 32'h1);
      data_in = 8'hA5;
      step();
      chk("s1_dest", 32'(dest_a), 32'h2);
      for (int i = 0; i < 3; i++) begin data_in = 8'(8'h10 + i); step(); end
      chk("s1_ld", 32'(ld_a), 32'h1);
      pkt_valid = 1'b0;
      step();
      chk("s1_lp_we", 32'(we_a), 32'h1);
      step();
      chk("s1_cpe", 32'(ri_a), 32'h1);
      step();
      chk("s1_dec", 32'(detect_add_a), 32'h1);

      // Channel 2 busy for 10 cycles; b times out at 8
      do_reset();
      fifo_empty = 3'b011; pkt_valid = 1'b1; data_in = 8'h02;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("s2_busy", 32'({busy_a, detect_add_a}), 32'h2);
      end
      fifo_empty = 3'b111;
      step();
      chk("s2_lfd", 32'(lfd_a), 32'h1);
      pkt_valid = 1'b0;
      step(); step();

      // Channel 0 never drains: timeout drop on b
      do_reset();
      fifo_empty = 3'b110; pkt_valid = 1'b1; data_in = 8'h00;
      drop_step = -1; pulses = 0;
      for (int i = 1; i <= 14; i++) begin
         step();
         if (drop_b) begin pulses++; if (drop_step < 0) drop_step = i; end
      end
      chk("s3_drop_step", 32'(drop_step), 32'd9);
      chk("s3_pulses", 32'(pulses), 32'd1);
      pkt_valid = 1'b0;
      step();
      chk("s3_dec", 32'(detect_add_b), 32'h1);

      // Invalid address 3
      do_reset();
      pkt_valid = 1'b1; data_in = 8'h03;
      step();
      chk("s4_drop", 32'({drop_a, we_a, dest_a}), 32'h10);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("s4_nowr", 32'({drop_a, we_a, dest_a}), 32'h0);
      end
      pkt_valid = 1'b0;
      step();

      // FIFO full mid-payload, low_pkt_valid on release
      do_reset();
      pkt_valid = 1'b1; data_in = 8'h01;
      step(); step(); step();
      fifo_full = 3'b010;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("s5_full", 32'(full_a), 32'h1);
      end
      fifo_full = 3'b000; low_pkt_valid = 1'b1;
      step();
      chk("s5_laf", 32'({laf_a, we_a}), 32'h3);
      step();
      chk("s5_lp", 32'(we_a), 32'h1);
      low_pkt_valid = 1'b0; pkt_valid = 1'b0;
      step(); step();

      // Soft reset on other channel ignored, on own channel aborts; rst mid-load
      do_reset();
      pkt_valid = 1'b1; data_in = 8'h01;
      step(); step();
      fifo_full = 3'b010;
      step();
      soft_reset = 3'b001;
      step();
      chk("s6_ignore", 32'(full_a), 32'h1);
      soft_reset = 3'b011;
      step();
      chk("s6_abort", 32'({detect_add_a, dest_a}), 32'h8);
      soft_reset = 3'b000; fifo_full = 3'b000; data_in = 8'h01;
      step(); step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("s6_rst", 32'(out_b), 32'h800);
      pkt_valid = 1'b0;
      step();

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         rst           = ($urandom % 64) == 0;
         pkt_valid     = ($urandom % 4) != 0;
         data_in       = 8'($urandom);
         fifo_empty    = 3'($urandom);
         fifo_full     = (($urandom % 4) == 0) ? 3'($urandom) : 3'b000;
         soft_reset    = (($urandom % 16) == 0) ? 3'($urandom) : 3'b000;
         parity_done   = ($urandom % 4) == 0;
         low_pkt_valid = ($urandom % 2) == 1;
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
